// File: rtl/layer0_input_quantizer_if.sv
// Stream bundle between the readout sample source, the layer-0 input
// quantizer and the layer-0 LUT neurons. The slave side is the
// quantizer. The master side is whoever drives samples and consumes frames.
interface layer0_input_quantizer_if #(
    parameter int DW = 16,
    parameter int QB = 2,
    parameter int NF = 3
);
    logic signed [DW-1:0]    s_data;
    logic                    s_valid;
    logic                    s_last;
    logic                    s_ready;
    logic [NF*QB-1:0]        m_data;
    logic                    m_valid;
    logic                    m_ready;

    modport master (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_data, m_valid
    );

    modport slave (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_data, m_valid
    );
endinterface

// File: rtl/layer0_input_quantizer.sv
// layer0_input_quantizer: quantizes signed readout samples to QB-bit codes
// and packs NF of them into one frame for the layer-0 LUT neurons.
// Optional feature: define LAYER0_IN_SAT_CNT_EN to add the sat_cnt port,
// a saturating count of accepted samples that had to be clamped.
module layer0_input_quantizer #(
    parameter int DW    = 16,
    parameter int QB    = 2,
    parameter int NF    = 3,
    parameter int SHIFT = 12
) (
    input  logic clk,
    input  logic rst,
    layer0_input_quantizer_if.slave bus,
    output logic frame_err
`ifdef LAYER0_IN_SAT_CNT_EN
    ,
    output logic [15:0] sat_cnt
`endif
);

    localparam int CW = (NF > 1) ? $clog2(NF) : 1;
    localparam logic signed [DW:0] OFFSET = $signed((DW + 1)'(2 ** (QB - 1)));
    localparam logic signed [DW:0] MAXC   = $signed((DW + 1)'(2 ** QB - 1));

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    out_state_t          state;
    out_state_t          state_next;
    logic [CW-1:0]       cnt;
    logic [NF*QB-1:0]    fill;
    logic [NF*QB-1:0]    frame_next;
    logic [NF*QB-1:0]    m_data_q;
    logic signed [DW:0]  shifted;
    logic signed [DW:0]  t;
    logic [QB-1:0]       code;
    logic                last_slot;
    logic                m_valid_int;
    logic                accept;
    logic                complete;
    logic                misalign;
    logic                drain;

    assign m_valid_int = (state == FULL);
    assign last_slot   = (cnt == CW'(NF - 1));
    assign bus.s_ready = !rst && !(last_slot && m_valid_int && !bus.m_ready);
    assign accept      = bus.s_valid && bus.s_ready;
    assign complete    = accept && last_slot && bus.s_last;
    assign misalign    = accept && (last_slot != bus.s_last);
    assign drain       = m_valid_int && bus.m_ready;
    assign bus.m_valid = m_valid_int;
    assign bus.m_data  = m_data_q;

    // Scale the sample down, recentre it on the code range and clamp it.
    always_comb begin
        shifted = $signed({bus.s_data[DW-1], bus.s_data}) >>> SHIFT;
        t       = shifted + OFFSET;
        code    = '0;
        if (t[DW]) begin
            code = '0;
        end else if (t > MAXC) begin
            code = '1;
        end else begin
            code = t[QB-1:0];
        end
    end

    // The fill register with the current sample's code dropped into slot cnt.
    always_comb begin
        frame_next = fill;
        frame_next[int'(cnt)*QB +: QB] = code;
    end

    // Output register state: holds a frame until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // EMPTY/FULL transitions; a drain and a new frame in one cycle stays FULL.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (complete) state_next = FULL;
            FULL:    if (drain && !complete) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // Slot filling, frame hand-off and misaligned-frame discard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            fill      <= '0;
            m_data_q  <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= misalign;
            if (accept) begin
                if (complete) begin
                    m_data_q <= frame_next;
                    cnt      <= '0;
                end else if (misalign) begin
                    cnt      <= '0;
                end else begin
                    fill     <= frame_next;
                    cnt      <= cnt + CW'(1);
                end
            end
        end
    end

`ifdef LAYER0_IN_SAT_CNT_EN
    logic saturated;

    assign saturated = t[DW] || (t > MAXC);

    // Count accepted samples that were clamped, sticking at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt <= '0;
        end else if (accept && saturated && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_layer0_input_quantizer.sv
// Directed testbench for layer0_input_quantizer with default parameters.
// Each vector is one clock cycle: inputs driven on the falling edge,
// s_ready checked before the rising edge, registered outputs just after.
module tb_layer0_input_quantizer;

    typedef struct {
        logic        valid;
        logic        last;
        logic        mready;
        logic [15:0] data;
        logic        exp_sr;
        logic        exp_mv;
        logic [5:0]  exp_md;
        logic        exp_err;
        logic [15:0] exp_sat;
    } vec_t;

    logic clk;
    logic rst;
    logic frame_err;
`ifdef LAYER0_IN_SAT_CNT_EN
    logic [15:0] sat_cnt;
`endif

    int tests_run;
    int tests_failed;

    vec_t vecs[20];
    vec_t rvecs[5];
    vec_t pvecs[4];

    layer0_input_quantizer_if #(.DW(16), .QB(2), .NF(3)) bus ();

    layer0_input_quantizer #(
        .DW(16),
        .QB(2),
        .NF(3),
        .SHIFT(12)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .frame_err(frame_err)
`ifdef LAYER0_IN_SAT_CNT_EN
        ,
        .sat_cnt(sat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        bus.s_valid = v.valid;
        bus.s_last  = v.last;
        bus.m_ready = v.mready;
        bus.s_data  = v.data;
    endtask

    task automatic runVector(input vec_t v, input string tag);
        applyStimulus(v);
        #1;
        checkOutput({tag, " s_ready"}, int'(bus.s_ready), int'(v.exp_sr));
        @(posedge clk);
        #1;
        checkOutput({tag, " m_valid"}, int'(bus.m_valid), int'(v.exp_mv));
        checkOutput({tag, " m_data"}, int'(bus.m_data), int'(v.exp_md));
        checkOutput({tag, " frame_err"}, int'(frame_err), int'(v.exp_err));
`ifdef LAYER0_IN_SAT_CNT_EN
        checkOutput({tag, " sat_cnt"}, int'(sat_cnt), int'(v.exp_sat));
`endif
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        //            valid last mrdy data      sr  mv  md         err sat
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 6'b000000, 1'b0, 16'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 16'hF000, 1'b1, 1'b0, 6'b000000, 1'b0, 16'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 16'h1000, 1'b1, 1'b1, 6'b110110, 1'b0, 16'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 16'h7530, 1'b1, 1'b0, 6'b110110, 1'b0, 16'd1};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b0, 6'b110110, 1'b0, 16'd2};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 16'hE000, 1'b1, 1'b1, 6'b000011, 1'b0, 16'd2};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 16'h1000, 1'b1, 1'b1, 6'b000011, 1'b0, 16'd2};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 6'b000011, 1'b0, 16'd2};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 16'hF000, 1'b0, 1'b1, 6'b000011, 1'b0, 16'd2};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 16'hF000, 1'b1, 1'b1, 6'b011011, 1'b0, 16'd2};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 6'b011011, 1'b0, 16'd2};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 6'b011011, 1'b0, 16'd2};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 6'b011011, 1'b1, 16'd2};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b0, 6'b011011, 1'b0, 16'd3};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 16'h1000, 1'b1, 1'b0, 6'b011011, 1'b0, 16'd3};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 6'b101100, 1'b0, 16'd3};
        vecs[16] = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 6'b101100, 1'b0, 16'd3};
        vecs[17] = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 6'b101100, 1'b0, 16'd3};
        vecs[18] = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 6'b101100, 1'b1, 16'd3};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 6'b101100, 1'b0, 16'd3};

        // Hold a frame, then leave two samples of the next one in flight.
        rvecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 6'b101100, 1'b0, 16'd3};
        rvecs[1] = '{1'b1, 1'b0, 1'b0, 16'h1000, 1'b1, 1'b0, 6'b101100, 1'b0, 16'd3};
        rvecs[2] = '{1'b1, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b1, 6'b001110, 1'b0, 16'd4};
        rvecs[3] = '{1'b1, 1'b0, 1'b0, 16'h1000, 1'b1, 1'b1, 6'b001110, 1'b0, 16'd4};
        rvecs[4] = '{1'b1, 1'b0, 1'b0, 16'h1000, 1'b1, 1'b1, 6'b001110, 1'b0, 16'd4};

        // After the reset pulse a fresh frame must pack from slot 0.
        pvecs[0] = '{1'b1, 1'b0, 1'b1, 16'hF000, 1'b1, 1'b0, 6'b000000, 1'b0, 16'd0};
        pvecs[1] = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 6'b000000, 1'b0, 16'd0};
        pvecs[2] = '{1'b1, 1'b1, 1'b1, 16'h1000, 1'b1, 1'b1, 6'b111001, 1'b0, 16'd0};
        pvecs[3] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 6'b111001, 1'b0, 16'd0};

        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        bus.s_data  = '0;

        #12;
        checkOutput("reset m_valid", int'(bus.m_valid), 0);
        checkOutput("reset m_data", int'(bus.m_data), 0);
        checkOutput("reset frame_err", int'(frame_err), 0);
        checkOutput("reset s_ready", int'(bus.s_ready), 0);
`ifdef LAYER0_IN_SAT_CNT_EN
        checkOutput("reset sat_cnt", int'(sat_cnt), 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            runVector(vecs[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 5; i++) begin
            runVector(rvecs[i], $sformatf("prerst%0d", i));
        end

        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        rst         = 1'b1;
        #1;
        checkOutput("midrst m_valid", int'(bus.m_valid), 0);
        checkOutput("midrst m_data", int'(bus.m_data), 0);
        checkOutput("midrst s_ready", int'(bus.s_ready), 0);
        checkOutput("midrst frame_err", int'(frame_err), 0);
`ifdef LAYER0_IN_SAT_CNT_EN
        checkOutput("midrst sat_cnt", int'(sat_cnt), 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            runVector(pvecs[i], $sformatf("postrst%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
